// File: rtl/register_write_arbiter.sv
// Shared WIDTH-bit register written by N requesters through a round-robin arbiter.
// A requester can hold the grant for a bounded burst of up to MAX_LOCK consecutive writes.
module register_write_arbiter #(
    parameter int               N        = 4,
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INIT     = {WIDTH{1'b0}},
    parameter int               MAX_LOCK = 4
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESET,
    input  logic [N-1:0]         REQ,
    input  logic [N*WIDTH-1:0]   DATA,
    input  logic [N-1:0]         LOCK,
    output logic [N-1:0]         ACK,
    output logic [WIDTH-1:0]     O,
    output logic [$clog2(N)-1:0] OWNER,
    output logic                 VALID
);

    localparam int                 IDX_W      = $clog2(N);
    localparam int                 CNT_W      = 4;
    localparam logic [CNT_W-1:0]   MAX_LOCK_C = CNT_W'(MAX_LOCK);
    localparam logic [N-1:0]       ONE_HOT_0  = {{(N-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] ptr_r;
    logic             locked_r;
    logic [IDX_W-1:0] lock_id_r;
    logic [CNT_W-1:0] lock_cnt_r;
    logic [WIDTH-1:0] o_r;
    logic [N-1:0]     ack_r;
    logic [IDX_W-1:0] owner_r;
    logic             valid_r;

    logic             grant_s;
    logic [IDX_W-1:0] grant_id_s;
    logic             lock_hit_s;

    // Index base+off modulo N, for off in 0..N-1.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

    // Grant selection: honour an unexpired lock, otherwise scan from ptr.
    always_comb begin
        grant_s    = 1'b0;
        grant_id_s = {IDX_W{1'b0}};
        lock_hit_s = locked_r && REQ[lock_id_r] && (lock_cnt_r < MAX_LOCK_C);
        if (lock_hit_s) begin
            grant_s    = 1'b1;
            grant_id_s = lock_id_r;
        end else begin
            // Scanning from the far end lets the nearest requester after ptr win last.
            for (int i = N - 1; i >= 0; i--) begin
                if (REQ[wrap_add(ptr_r, i)]) begin
                    grant_s    = 1'b1;
                    grant_id_s = wrap_add(ptr_r, i);
                end else begin
                    grant_s    = grant_s;
                end
            end
        end
    end

    // Register bank, arbitration pointer and lock bookkeeping.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            ptr_r      <= {IDX_W{1'b0}};
            locked_r   <= 1'b0;
            lock_id_r  <= {IDX_W{1'b0}};
            lock_cnt_r <= {CNT_W{1'b0}};
            o_r        <= INIT;
            ack_r      <= {N{1'b0}};
            owner_r    <= {IDX_W{1'b0}};
            valid_r    <= 1'b0;
        end else if (grant_s) begin
            o_r     <= DATA[int'(grant_id_s)*WIDTH +: WIDTH];
            ack_r   <= ONE_HOT_0 << grant_id_s;
            owner_r <= grant_id_s;
            valid_r <= 1'b1;
            ptr_r   <= wrap_add(grant_id_s, 1);
            if (LOCK[grant_id_s]) begin
                locked_r   <= 1'b1;
                lock_id_r  <= grant_id_s;
                // A burst that hit the limit restarts counting rather than overflowing.
                lock_cnt_r <= lock_hit_s ? lock_cnt_r + 4'd1 : 4'd1;
            end else begin
                locked_r   <= 1'b0;
                lock_cnt_r <= {CNT_W{1'b0}};
            end
        end else begin
            ack_r      <= {N{1'b0}};
            locked_r   <= 1'b0;
            lock_cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign O     = o_r;
    assign ACK   = ack_r;
    assign OWNER = owner_r;
    assign VALID = valid_r;

endmodule
